nes_input_ports: RTL

CPU-facing controller for the two NES controller ports at $4016/$4017. It owns the strobe latch and per-port serial shift registers for standard pads and the Four Score multitap. It also routes zapper light/trigger status onto the port data lines. It sits between the CPU bus decode and the pad/zapper sources, and sequences every serial read the game performs.

---
 rtl/nes_input_pkg.sv | 42 ++++
 rtl/nes_input_ports_shifter.sv | 36 +++
 rtl/nes_input_ports.sv | 116 +++++++++++
 3 files changed

// File: rtl/nes_input_pkg.sv
// Shared types and constants for the NES controller port block.
// Device codes, register geometry and Four Score signatures.
package nes_input_pkg;

    typedef enum logic [1:0] {
        DEV_NONE   = 2'd0,
        DEV_PAD    = 2'd1,
        DEV_ZAPPER = 2'd2
    } dev_e;

    localparam int SR_W  = 24;
    localparam int CNT_W = 5;

    localparam logic [CNT_W-1:0] CNT_SAT = 5'd24;

    localparam logic [7:0] SIG_4016_DEF = 8'h08;
    localparam logic [7:0] SIG_4017_DEF = 8'h04;

    // Code 3 is reserved and behaves exactly like an empty port.
    function automatic dev_e decode_dev(input logic [1:0] code);
        dev_e d;
        case (code)
            2'd1:    d = DEV_PAD;
            2'd2:    d = DEV_ZAPPER;
            default: d = DEV_NONE;
        endcase
        return d;
    endfunction

    function automatic logic [SR_W-1:0] reload_word(
        input logic       fs,
        input logic [7:0] sig,
        input logic [7:0] pad_b,
        input logic [7:0] pad_a
    );
        logic [SR_W-1:0] w;
        if (fs) w = {sig, pad_b, pad_a};
        else    w = {16'hFFFF, pad_a};
        return w;
    endfunction

endpackage

// File: rtl/nes_input_ports_shifter.sv
// One controller port serial register with saturating read counter.
// Shifts toward bit 0, back-filling ones so over-reads return 1.
module input_port_shifter
    import nes_input_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            shift,
    input  logic [SR_W-1:0] load_val,
    input  dev_e            dev,
    output logic            d0
);

    logic [SR_W-1:0]  sr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat;

    assign sat = (cnt_q == CNT_SAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            sr_q  <= load_val;
            cnt_q <= '0;
        end else if (shift && !sat) begin
            sr_q  <= {1'b1, sr_q[SR_W-1:1]};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign d0 = (dev == DEV_PAD) & sr_q[0];

endmodule

// File: rtl/nes_input_ports.sv
// CPU-side $4016/$4017 controller: strobe latch, config capture,
// Four Score qualification and zapper status routing.
module nes_input_ports
    import nes_input_pkg::*;
#(
    parameter logic [7:0] SIG_4016 = SIG_4016_DEF,
    parameter logic [7:0] SIG_4017 = SIG_4017_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_4016,
    input  logic       wr_data,
    input  logic       rd_4016,
    input  logic       rd_4017,
    input  logic [7:0] pad1,
    input  logic [7:0] pad2,
    input  logic [7:0] pad3,
    input  logic [7:0] pad4,
    input  logic [1:0] port1_dev,
    input  logic [1:0] port2_dev,
    input  logic       fourscore_en,
    input  logic       zap_light,
    input  logic       zap_trigger,
    output logic [4:0] out_4016,
    output logic [4:0] out_4017,
    output logic       strobe
);

    logic strobe_q;
    dev_e dev1_q;
    dev_e dev2_q;
    logic fs_en_q;
    logic zap_light_q;
    logic zap_trig_q;

    dev_e dev1_in;
    dev_e dev2_in;
    logic fs_load;

    logic            shift1;
    logic            shift2;
    logic [SR_W-1:0] reload1;
    logic [SR_W-1:0] reload2;
    logic            d0_1;
    logic            d0_2;
    logic            zap1;
    logic            zap2;

    assign dev1_in = decode_dev(port1_dev);
    assign dev2_in = decode_dev(port2_dev);

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_q    <= 1'b0;
            dev1_q      <= DEV_NONE;
            dev2_q      <= DEV_NONE;
            fs_en_q     <= 1'b0;
            zap_light_q <= 1'b0;
            zap_trig_q  <= 1'b0;
        end else begin
            if (wr_4016)
                strobe_q <= wr_data;
            if (strobe_q) begin
                dev1_q  <= dev1_in;
                dev2_q  <= dev2_in;
                fs_en_q <= fourscore_en;
            end
            zap_light_q <= zap_light;
            zap_trig_q  <= zap_trigger;
        end
    end

    // Reloads only happen while strobe is high, which is exactly when the
    // config registers capture, so the reload uses the config being latched.
    assign fs_load = fourscore_en
                   && (dev1_in == DEV_PAD)
                   && (dev2_in == DEV_PAD);

    assign reload1 = reload_word(fs_load, SIG_4016, pad3, pad1);
    assign reload2 = reload_word(fs_load, SIG_4017, pad4, pad2);

    // A $4016 write in the same cycle wins over a $4016 read.
    assign shift1 = rd_4016 & ~strobe_q & ~wr_4016;
    assign shift2 = rd_4017 & ~strobe_q;

    input_port_shifter u_port1 (
        .clk      (clk),
        .reset    (reset),
        .load     (strobe_q),
        .shift    (shift1),
        .load_val (reload1),
        .dev      (dev1_q),
        .d0       (d0_1)
    );

    input_port_shifter u_port2 (
        .clk      (clk),
        .reset    (reset),
        .load     (strobe_q),
        .shift    (shift2),
        .load_val (reload2),
        .dev      (dev2_q),
        .d0       (d0_2)
    );

    assign zap1 = (dev1_q == DEV_ZAPPER);
    assign zap2 = (dev2_q == DEV_ZAPPER);

    assign out_4016 = {zap1 & zap_trig_q, zap1 & zap_light_q, 2'b00, d0_1};
    assign out_4017 = {zap2 & zap_trig_q, zap2 & zap_light_q, 2'b00, d0_2};
    assign strobe   = strobe_q;

    logic unused_fs;
    assign unused_fs = fs_en_q;

endmodule
